// File: rtl/gfp_pkg.sv
// rtl/gfp_pkg.sv - GF(p) ALU shared op encodings, FSM state type and default width
package gfp_pkg;

  localparam int GFP_WIDTH_DEFAULT = 32;

  localparam logic [1:0] GFP_OP_ADD = 2'd0;
  localparam logic [1:0] GFP_OP_SUB = 2'd1;
  localparam logic [1:0] GFP_OP_MUL = 2'd2;
  localparam logic [1:0] GFP_OP_DIV = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXEC,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } gfp_state_e;

endpackage

// File: rtl/gfp_modaddsub.sv
// rtl/gfp_modaddsub.sv - combinational (a +/- b) mod p, operands assumed already reduced
module gfp_modaddsub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_prime,
  input  logic             i_sub,
  output logic [WIDTH-1:0] o_y
);

  logic [WIDTH:0] p_ext;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] dif;

  // One extra bit keeps a+b exact even when p is close to 2^WIDTH.
  always_comb begin
    p_ext = {1'b0, i_prime};
    sum   = {1'b0, i_a} + {1'b0, i_b};
    dif   = {1'b0, i_a} - {1'b0, i_b};
    if (i_sub) begin
      if (i_a < i_b) dif = dif + p_ext;
      o_y = dif[WIDTH-1:0];
    end else begin
      if (sum >= p_ext) sum = sum - p_ext;
      o_y = sum[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/gfp_alu.sv
// rtl/gfp_alu.sv - GF(p) add/sub/mul/div unit with valid/ready request and done pulse
// Divide hardware is built only when GFP_ALU_DIV_EN is defined.
module gfp_alu
  import gfp_pkg::*;
#(
  parameter int WIDTH    = GFP_WIDTH_DEFAULT,
  parameter int ITER_MAX = 2*WIDTH+2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_prime,
  output logic [WIDTH-1:0] o_result,
  output logic             o_done,
  output logic             o_err
);

  localparam int CW = $clog2(ITER_MAX+1);

  gfp_state_e       state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, p_q, p_d;
  logic [WIDTH-1:0] acc_q, acc_d, res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             perr_q, perr_d, err_q, err_d, done_q, done_d;

  logic [WIDTH-1:0] as_a, as_b, as_y, madd_y, mul_next;
  logic             as_sub;

  // Shared add/sub unit doubles the accumulator while multiplying.
  assign as_a   = (state_q == ST_MUL) ? acc_q : a_q;
  assign as_b   = (state_q == ST_MUL) ? acc_q : b_q;
  assign as_sub = (state_q != ST_MUL) && (op_q == GFP_OP_SUB);

  gfp_modaddsub #(.WIDTH(WIDTH)) u_addsub (
    .i_a(as_a), .i_b(as_b), .i_prime(p_q), .i_sub(as_sub), .o_y(as_y)
  );

  gfp_modaddsub #(.WIDTH(WIDTH)) u_mul_add (
    .i_a(as_y), .i_b(b_q), .i_prime(p_q), .i_sub(1'b0), .o_y(madd_y)
  );

  assign mul_next = a_q[WIDTH-1] ? madd_y : as_y;

`ifdef GFP_ALU_DIV_EN
  logic [WIDTH-1:0] u_q, u_d, v_q, v_d, x1_q, x1_d, x2_q, x2_d, dsub_y;
  logic             u_ge_v;

  function automatic logic [WIDTH-1:0] half_mod(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] p);
    return x[0] ? WIDTH'(({1'b0, x} + {1'b0, p}) >> 1) : (x >> 1);
  endfunction

  assign u_ge_v = (u_q >= v_q);

  gfp_modaddsub #(.WIDTH(WIDTH)) u_div_sub (
    .i_a(u_ge_v ? x1_q : x2_q), .i_b(u_ge_v ? x2_q : x1_q),
    .i_prime(p_q), .i_sub(1'b1), .o_y(dsub_y)
  );
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      perr_q  <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
`ifdef GFP_ALU_DIV_EN
      u_q     <= '0;
      v_q     <= '0;
      x1_q    <= '0;
      x2_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      perr_q  <= perr_d;
      err_q   <= err_d;
      done_q  <= done_d;
`ifdef GFP_ALU_DIV_EN
      u_q     <= u_d;
      v_q     <= v_d;
      x1_q    <= x1_d;
      x2_q    <= x2_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    acc_d   = acc_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    perr_d  = perr_q;
    err_d   = err_q;
    done_d  = 1'b0;
`ifdef GFP_ALU_DIV_EN
    u_d     = u_q;
    v_d     = v_q;
    x1_d    = x1_q;
    x2_d    = x2_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          op_d   = i_op;
          a_d    = i_a;
          b_d    = i_b;
          p_d    = i_prime;
          acc_d  = '0;
          cnt_d  = '0;
          perr_d = 1'b0;
          case (i_op)
            GFP_OP_MUL: state_d = ST_MUL;
`ifdef GFP_ALU_DIV_EN
            GFP_OP_DIV: begin
              if (i_b != '0) begin
                state_d = ST_DIV;
                u_d     = i_b;
                v_d     = i_prime;
                x1_d    = i_a;
                x2_d    = '0;
              end else begin
                state_d = ST_EXEC;
              end
            end
`endif
            default: state_d = ST_EXEC;
          endcase
        end
      end
      // Reached by add/sub and by every divide that must fail immediately.
      ST_EXEC: begin
        if (op_q == GFP_OP_ADD || op_q == GFP_OP_SUB) begin
          acc_d = as_y;
        end else begin
          acc_d  = '0;
          perr_d = 1'b1;
        end
        state_d = ST_DONE;
      end
      ST_MUL: begin
        acc_d = mul_next;
        a_d   = a_q << 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH-1)) state_d = ST_DONE;
      end
`ifdef GFP_ALU_DIV_EN
      ST_DIV: begin
        cnt_d = cnt_q + CW'(1);
        if (u_q == WIDTH'(1)) begin
          acc_d   = x1_q;
          state_d = ST_DONE;
        end else if (v_q == WIDTH'(1)) begin
          acc_d   = x2_q;
          state_d = ST_DONE;
        end else if (cnt_q >= CW'(ITER_MAX-1)) begin
          acc_d   = '0;
          perr_d  = 1'b1;
          state_d = ST_DONE;
        end else if (!u_q[0]) begin
          u_d  = u_q >> 1;
          x1_d = half_mod(x1_q, p_q);
        end else if (!v_q[0]) begin
          v_d  = v_q >> 1;
          x2_d = half_mod(x2_q, p_q);
        end else if (u_ge_v) begin
          u_d  = u_q - v_q;
          x1_d = dsub_y;
        end else begin
          v_d  = v_q - u_q;
          x2_d = dsub_y;
        end
      end
`endif
      ST_DONE: begin
        res_d   = acc_q;
        err_d   = perr_q;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_ready  = (state_q == ST_IDLE);
  assign o_result = res_q;
  assign o_done   = done_q;
  assign o_err    = err_q;

endmodule

// File: tb/tb_gfp_alu.sv
// tb/tb_gfp_alu.sv - directed vector bench for gfp_alu with latency, back-to-back and reset sequences
module tb_gfp_alu;
  import gfp_pkg::*;

  localparam logic [31:0] P = 32'hFFFFFFFB;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic        ready, done, err;
  logic [1:0]  op = 2'd0;
  logic [31:0] a = '0, b = '0, prime = P;
  logic [31:0] result;

  int checks = 0;
  int failures = 0;

  gfp_alu dut (
    .i_clk(clk), .i_rst(rst_n), .i_valid(valid), .o_ready(ready),
    .i_op(op), .i_a(a), .i_b(b), .i_prime(prime),
    .o_result(result), .o_done(done), .o_err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] p;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge with the unit idle; returns at the negedge where o_done is seen.
  task automatic do_op(input logic [1:0] o, input logic [31:0] pp, input logic [31:0] aa,
                       input logic [31:0] bb, output logic [31:0] res, output logic e,
                       output int lat, output logic rdy);
    valid = 1'b1; op = o; prime = pp; a = aa; b = bb;
    @(posedge clk);
    #1;
    valid = 1'b0; op = ~o; prime = 32'h5; a = ~aa; b = 32'h0;
    lat = -1; res = '0; e = 1'b0; rdy = 1'b0;
    for (int n = 1; n <= 200 && lat < 0; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        lat = n; res = result; e = err; rdy = ready;
      end
    end
  endtask

  initial begin
    logic [31:0] res;
    logic        e, rdy, saw_done;
    int          lat;

    vecs[0]  = '{GFP_OP_ADD, P, 32'hFFFFFFFA, 32'hFFFFFFFA, 32'hFFFFFFF9, 1'b0, 2};
    vecs[1]  = '{GFP_OP_SUB, P, 32'd3, 32'd5, 32'hFFFFFFF9, 1'b0, 2};
    vecs[2]  = '{GFP_OP_SUB, P, 32'd5, 32'd3, 32'd2, 1'b0, 2};
    vecs[3]  = '{GFP_OP_MUL, P, 32'hFFFFFFFA, 32'hFFFFFFFA, 32'd1, 1'b0, 33};
    vecs[4]  = '{GFP_OP_MUL, P, 32'h12345678, 32'd0, 32'd0, 1'b0, 33};
    vecs[5]  = '{GFP_OP_ADD, P, 32'hFFFFFFFA, 32'd1, 32'd0, 1'b0, 2};
    vecs[6]  = '{GFP_OP_SUB, P, 32'd0, 32'd0, 32'd0, 1'b0, 2};
    vecs[7]  = '{GFP_OP_ADD, 32'd7, 32'd5, 32'd6, 32'd4, 1'b0, 2};
    vecs[8]  = '{GFP_OP_MUL, 32'd7, 32'd3, 32'd5, 32'd1, 1'b0, 33};
`ifdef GFP_ALU_DIV_EN
    vecs[9]  = '{GFP_OP_DIV, P, 32'd1, 32'd2, 32'h7FFFFFFE, 1'b0, 3};
    vecs[10] = '{GFP_OP_DIV, P, 32'd7, 32'd0, 32'd0, 1'b1, 2};
    vecs[11] = '{GFP_OP_DIV, 32'd7, 32'd3, 32'd5, 32'd2, 1'b0, 4};
    vecs[12] = '{GFP_OP_DIV, P, 32'd5, 32'd1, 32'd5, 1'b0, 2};
`else
    vecs[9]  = '{GFP_OP_DIV, P, 32'd1, 32'd2, 32'd0, 1'b1, 2};
    vecs[10] = '{GFP_OP_DIV, P, 32'd7, 32'd0, 32'd0, 1'b1, 2};
    vecs[11] = '{GFP_OP_DIV, 32'd7, 32'd3, 32'd5, 32'd0, 1'b1, 2};
    vecs[12] = '{GFP_OP_DIV, P, 32'd5, 32'd1, 32'd0, 1'b1, 2};
`endif
    vecs[13] = '{GFP_OP_MUL, P, 32'd2, 32'd3, 32'd6, 1'b0, 33};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset ready", {31'd0, ready}, 32'd1);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset err", {31'd0, err}, 32'd0);
    check("reset result", result, 32'd0);

    // Each request is issued in the done cycle of the previous one.
    for (int i = 0; i < 14; i++) begin
      do_op(vecs[i].op, vecs[i].p, vecs[i].a, vecs[i].b, res, e, lat, rdy);
      check($sformatf("v%0d result", i), res, vecs[i].exp_res);
      check($sformatf("v%0d err", i), {31'd0, e}, {31'd0, vecs[i].exp_err});
      check($sformatf("v%0d latency", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d ready_at_done", i), {31'd0, rdy}, 32'd1);
    end

    @(negedge clk);
    check("done one cycle", {31'd0, done}, 32'd0);
    check("result held", result, 32'd6);

    // Reset lands on edge 10 of a multiply.
    valid = 1'b1; op = GFP_OP_MUL; prime = P; a = 32'hFFFFFFFA; b = 32'hFFFFFFFA;
    @(posedge clk);
    #1 valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("midreset ready", {31'd0, ready}, 32'd1);
    check("midreset done", {31'd0, done}, 32'd0);
    check("midreset result", result, 32'd0);
    saw_done = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("midreset no done", {31'd0, saw_done}, 32'd0);

    do_op(GFP_OP_ADD, P, 32'd1, 32'd1, res, e, lat, rdy);
    check("post reset add", res, 32'd2);
    check("post reset err", {31'd0, e}, 32'd0);
    check("post reset latency", lat, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
